// File: rtl/mips_mem_bridge.sv
// Purpose : address decoder between the mips core memory port and system RAM, with an
//           MMIO window holding a free-running timer/compare/irq and a byte TX FIFO.
// Latency : reads are combinational (MMIO words come from registers only); writes take effect at
//           the next posedge. FIFO push is visible on tx_valid one cycle later.
// Backpressure: the console sink stalls the FIFO via tx_ready. A push into a full FIFO is dropped
//           and flags ovf, unless a pop happens in the same cycle. The core is never stalled.
//
// Ports:
//   clk, rstb                  clock, async active-low reset
//   cpu_addr/_wr_data/_wr_ena  core memory port (one word write per strobe cycle)
//   cpu_rd_data                read data back to core (RAM or MMIO word)
//   ram_addr/_wr_data/_wr_ena  RAM side; the write strobe is suppressed for MMIO addresses
//   ram_rd_data                RAM combinational read data
//   tx_data/tx_valid/tx_ready  console sink handshake, FIFO head byte
//   irq                        timer compare hit (sticky until W1C)
module mips_mem_bridge #(
  parameter logic [15:0] MMIO_BASE = 16'hFFFF,
  parameter int          TX_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rstb,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wr_data,
  input  logic        cpu_wr_ena,
  output logic [31:0] cpu_rd_data,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wr_data,
  output logic        ram_wr_ena,
  input  logic [31:0] ram_rd_data,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        irq
);

  localparam int              PTR_W     = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
  localparam logic [4:0]      DEPTH_CNT = 5'(TX_DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  // Decode. Only [31:16] and [3:2] matter, so the window aliases every 16 bytes.
  logic       mmioSel;
  logic [1:0] regOff;
  logic       mmioWr;
  logic       wrCmp;
  logic       wrStatus;
  logic       wrTxd;

  assign mmioSel  = (cpu_addr[31:16] == MMIO_BASE);
  assign regOff   = cpu_addr[3:2];
  assign mmioWr   = cpu_wr_ena & mmioSel;
  assign wrCmp    = mmioWr & (regOff == 2'd1);
  assign wrStatus = mmioWr & (regOff == 2'd2);
  assign wrTxd    = mmioWr & (regOff == 2'd3);

  assign ram_addr    = cpu_addr;
  assign ram_wr_data = cpu_wr_data;
  assign ram_wr_ena  = cpu_wr_ena & ~mmioSel;

  // Timer state
  logic [31:0] countReg;
  logic [31:0] cmpReg;
  logic        hitReg;
  logic        ovfReg;

  // TX FIFO state
  logic [7:0]       fifoMem [TX_DEPTH];
  logic [PTR_W-1:0] rdPtr;
  logic [PTR_W-1:0] wrPtr;
  logic [4:0]       fifoCnt;
  logic             fifoFull;
  logic             fifoEmpty;
  logic             popEn;
  logic             pushEn;
  logic             pushDrop;

  assign fifoFull  = (fifoCnt == DEPTH_CNT);
  assign fifoEmpty = (fifoCnt == 5'd0);
  assign popEn     = ~fifoEmpty & tx_ready;
  // A pop in the same cycle frees the slot the push needs, so a full FIFO still accepts.
  assign pushEn    = wrTxd & (~fifoFull | popEn);
  assign pushDrop  = wrTxd & fifoFull & ~popEn;

  assign tx_valid = ~fifoEmpty;
  assign tx_data  = fifoMem[rdPtr];
  assign irq      = hitReg;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      countReg <= 32'd0;
      cmpReg   <= 32'hFFFF_FFFF;
      hitReg   <= 1'b0;
      ovfReg   <= 1'b0;
    end else begin
      countReg <= countReg + 32'd1;
      if (wrCmp) cmpReg <= cpu_wr_data;
      // Set terms are ORed after the clear so a coincident set wins over W1C.
      hitReg <= (hitReg & ~(wrStatus & cpu_wr_data[0])) | (countReg == cmpReg);
      ovfReg <= (ovfReg & ~(wrStatus & cpu_wr_data[3])) | pushDrop;
    end
  end

  // Storage is reset so tx_data reads 0 out of reset.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int i = 0; i < TX_DEPTH; i++) fifoMem[i] <= 8'd0;
    end else if (pushEn) begin
      fifoMem[wrPtr] <= cpu_wr_data[7:0];
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      rdPtr   <= '0;
      wrPtr   <= '0;
      fifoCnt <= 5'd0;
    end else begin
      if (pushEn) wrPtr <= wrPtr + PTR_ONE;
      if (popEn)  rdPtr <= rdPtr + PTR_ONE;
      case ({pushEn, popEn})
        2'b10:   fifoCnt <= fifoCnt + 5'd1;
        2'b01:   fifoCnt <= fifoCnt - 5'd1;
        default: fifoCnt <= fifoCnt;
      endcase
    end
  end

  // Read mux: MMIO words come from registered state only.
  logic [31:0] mmioWord;
  always_comb begin
    mmioWord = 32'd0;
    case (regOff)
      2'd0:    mmioWord = countReg;
      2'd1:    mmioWord = cmpReg;
      2'd2:    mmioWord = {23'd0, fifoCnt, ovfReg, fifoEmpty, fifoFull, hitReg};
      default: mmioWord = 32'd0;
    endcase
  end

  assign cpu_rd_data = mmioSel ? mmioWord : ram_rd_data;

endmodule

// File: tb/tb_mips_mem_bridge.sv
// Purpose : exercises mips_mem_bridge with directed scenarios and random traffic.
// Latency : inputs change 1 time unit after posedge; outputs are sampled on negedge.
// Backpressure: tx_ready is driven by the bench, both held low and randomised.
module tb_mips_mem_bridge;

  localparam int TX_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rstb = 1'b0;
  logic [31:0] cpu_addr = 32'd0;
  logic [31:0] cpu_wr_data = 32'd0;
  logic        cpu_wr_ena = 1'b0;
  logic [31:0] cpu_rd_data;
  logic [31:0] ram_addr;
  logic [31:0] ram_wr_data;
  logic        ram_wr_ena;
  logic [31:0] ram_rd_data = 32'd0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        irq;

  always #5 clk = ~clk;

  mips_mem_bridge #(.MMIO_BASE(16'hFFFF), .TX_DEPTH(TX_DEPTH)) dut (
    .clk(clk), .rstb(rstb),
    .cpu_addr(cpu_addr), .cpu_wr_data(cpu_wr_data), .cpu_wr_ena(cpu_wr_ena),
    .cpu_rd_data(cpu_rd_data),
    .ram_addr(ram_addr), .ram_wr_data(ram_wr_data), .ram_wr_ena(ram_wr_ena),
    .ram_rd_data(ram_rd_data),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .irq(irq)
  );

  int nChecks = 0;
  int nFails  = 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: timer as a plain cycle count, FIFO as a queue.
  logic [31:0] mCount, mCmp;
  bit          mHit, mOvf;
  logic [7:0]  mq[$];
  logic [7:0]  sinkQ[$];
  logic [31:0] sRd;
  logic        sIrq, sWe;

  function automatic logic [31:0] expWord(input logic [1:0] off);
    logic [31:0] st;
    int n;
    n  = mq.size();
    st = 32'(n) << 4;
    st[0] = mHit;
    st[1] = (n == TX_DEPTH);
    st[2] = (n == 0);
    st[3] = mOvf;
    case (off)
      2'd0:    return mCount;
      2'd1:    return mCmp;
      2'd2:    return st;
      default: return 32'd0;
    endcase
  endfunction

  task automatic modelReset();
    mCount = 32'd0;
    mCmp   = 32'hFFFF_FFFF;
    mHit   = 1'b0;
    mOvf   = 1'b0;
    mq.delete();
  endtask

  task automatic modelUpdate(input bit mmio, input logic [1:0] off);
    bit pop, wr, full, isPush, clr, nh, no;
    pop    = (mq.size() != 0) && tx_ready;
    wr     = cpu_wr_ena && mmio;
    full   = (mq.size() == TX_DEPTH);
    isPush = wr && (off == 2'd3);
    clr    = wr && (off == 2'd2);
    nh = (mCount == mCmp) || (mHit && !(clr && cpu_wr_data[0]));
    no = (isPush && full && !pop) || (mOvf && !(clr && cpu_wr_data[3]));
    if (wr && off == 2'd1) mCmp = cpu_wr_data;
    mCount = mCount + 32'd1;
    if (pop) void'(mq.pop_front());
    if (isPush && (!full || pop)) mq.push_back(cpu_wr_data[7:0]);
    mHit = nh;
    mOvf = no;
  endtask

  // One clock cycle with the currently driven inputs: check on negedge, advance model on posedge.
  task automatic step();
    bit mmio;
    logic [1:0] off;
    @(negedge clk);
    mmio = (cpu_addr[31:16] == 16'hFFFF);
    off  = cpu_addr[3:2];
    checkVal("rd_data", cpu_rd_data, mmio ? expWord(off) : ram_rd_data);
    checkVal("ram_wr_ena", 32'(ram_wr_ena), 32'(cpu_wr_ena && !mmio));
    checkVal("ram_addr", ram_addr, cpu_addr);
    checkVal("ram_wr_data", ram_wr_data, cpu_wr_data);
    checkVal("tx_valid", 32'(tx_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) checkVal("tx_data", 32'(tx_data), 32'(mq[0]));
    checkVal("irq", 32'(irq), 32'(mHit));
    sRd  = cpu_rd_data;
    sIrq = irq;
    sWe  = ram_wr_ena;
    if (tx_valid && tx_ready) sinkQ.push_back(tx_data);
    @(posedge clk);
    if (!rstb) modelReset();
    else modelUpdate(mmio, off);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    cpu_addr = a; cpu_wr_data = d; cpu_wr_ena = 1'b1;
    step();
    cpu_wr_ena = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a);
    cpu_addr = a; cpu_wr_ena = 1'b0; ram_rd_data = $urandom;
    step();
  endtask

  task automatic drain(input int budget);
    tx_ready = 1'b1;
    cpu_addr = 32'h0000_0100;
    for (int i = 0; i < budget; i++) step();
    tx_ready = 1'b0;
  endtask

  task automatic checkSink(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                           input logic [7:0] e2, input logic [7:0] e3, input logic [7:0] e4,
                           input int n);
    logic [7:0] e [5];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3; e[4] = e4;
    checkVal({tag, "_len"}, 32'(sinkQ.size()), 32'(n));
    for (int i = 0; i < n; i++)
      checkVal(tag, 32'(i < sinkQ.size() ? sinkQ[i] : 8'hXX), 32'(e[i]));
  endtask

  initial begin
    logic [31:0] v1, r, a;
    // ---------------- reset ----------------
    modelReset();
    rstb = 1'b0;
    #1;
    checkVal("rst_tx_valid", 32'(tx_valid), 32'd0);
    checkVal("rst_tx_data", 32'(tx_data), 32'd0);
    checkVal("rst_irq", 32'(irq), 32'd0);
    step(); step();
    rstb = 1'b1;

    // ---------------- 1: counter and CMP reset value ----------------
    rd(32'hFFFF_0000);
    checkVal("count_first", sRd, 32'd0);
    v1 = sRd;
    rd(32'hFFFF_0000); rd(32'hFFFF_0000); rd(32'hFFFF_0000);
    checkVal("count_diff3", sRd - v1, 32'd3);
    rd(32'hFFFF_0004);
    checkVal("cmp_reset", sRd, 32'hFFFF_FFFF);
    rd(32'hFFFF_0FF4);  // alias of COUNT at offset 0x4? no: [3:2]=01 -> CMP
    checkVal("cmp_alias", sRd, 32'hFFFF_FFFF);

    // ---------------- 2: RAM passthrough vs MMIO write ----------------
    wr(32'h0000_0040, 32'hDEAD_BEEF);
    checkVal("ram_we_on", 32'(sWe), 32'd1);
    rd(32'h0000_0040);
    checkVal("ram_we_off", 32'(sWe), 32'd0);
    wr(32'hFFFF_0004, 32'h1234_5678);
    checkVal("mmio_we", 32'(sWe), 32'd0);
    rd(32'hFFFF_0004);
    checkVal("cmp_written", sRd, 32'h1234_5678);
    wr(32'hFFFF_0000, 32'h0BAD_0BAD);  // COUNT is read-only
    rd(32'hFFFF_000C);
    checkVal("txd_reads0", sRd, 32'd0);

    // ---------------- 3: compare -> irq exactly 6 cycles after the write ----------------
    wr(32'hFFFF_0004, mCount + 32'd5);
    cpu_addr = 32'h0000_0200;
    for (int k = 1; k <= 5; k++) begin
      step();
      checkVal("irq_early", 32'(sIrq), 32'd0);
    end
    step();
    checkVal("irq_at6", 32'(sIrq), 32'd1);
    step();
    checkVal("irq_sticky", 32'(sIrq), 32'd1);
    wr(32'hFFFF_0008, 32'd1);
    rd(32'hFFFF_0008);
    checkVal("irq_cleared", 32'(sIrq), 32'd0);

    // set wins over a coincident W1C
    wr(32'hFFFF_0004, mCount + 32'd2);
    rd(32'h0000_0300);
    wr(32'hFFFF_0008, 32'd1);
    rd(32'h0000_0300);
    checkVal("set_wins", 32'(sIrq), 32'd1);
    wr(32'hFFFF_0008, 32'd1);
    rd(32'h0000_0300);
    checkVal("irq_clr2", 32'(sIrq), 32'd0);

    // ---------------- 4: overflow with stalled sink ----------------
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) wr(32'hFFFF_000C, 32'hA5A5_A500 | 32'(8'h41 + i));
    rd(32'hFFFF_0008);
    checkVal("status_ovf", sRd, 32'h0000_004A);
    sinkQ.delete();
    drain(8);
    checkSink("sink_4", 8'h41, 8'h42, 8'h43, 8'h44, 8'h00, 4);
    rd(32'hFFFF_0008);
    checkVal("status_drained", sRd, 32'h0000_000C);

    // ---------------- 5: push while full with a simultaneous pop ----------------
    wr(32'hFFFF_0008, 32'd8);
    for (int i = 0; i < 4; i++) wr(32'hFFFF_000C, 32'(8'h60 + i));
    sinkQ.delete();
    tx_ready = 1'b1;
    wr(32'hFFFF_000C, 32'h0000_0055);
    tx_ready = 1'b0;
    rd(32'hFFFF_0008);
    checkVal("status_fullpop", sRd, 32'h0000_0042);
    drain(8);
    checkSink("sink_5", 8'h60, 8'h61, 8'h62, 8'h63, 8'h55, 5);

    // ---------------- random traffic ----------------
    for (int n = 0; n < 400; n++) begin
      r = $urandom;
      tx_ready = ($urandom_range(0, 2) != 0);
      cpu_wr_ena = r[0];
      cpu_wr_data = $urandom;
      ram_rd_data = $urandom;
      if (r[3:1] < 3'd5) begin
        a = $urandom;
        cpu_addr = {16'hFFFF, a[15:0]};
        if (cpu_wr_ena && a[3:2] == 2'd1 && r[4]) cpu_wr_data = mCount + 32'($urandom_range(1, 8));
      end else begin
        a = $urandom;
        cpu_addr = {16'($urandom_range(0, 16'hFFFE)), a[15:0]};
      end
      step();
    end
    cpu_wr_ena = 1'b0;
    tx_ready = 1'b0;

    // ---------------- 6: reset mid-drain ----------------
    wr(32'hFFFF_0008, 32'd9);
    drain(6);
    for (int i = 0; i < 4; i++) wr(32'hFFFF_000C, 32'(8'h70 + i));
    tx_ready = 1'b1;
    rd(32'h0000_0100);
    checkVal("pre_rst_cnt", 32'(mq.size()), 32'd3);
    rstb = 1'b0;
    modelReset();
    cpu_addr = 32'hFFFF_0008;
    #1;
    checkVal("rst_mid_valid", 32'(tx_valid), 32'd0);
    checkVal("rst_mid_status", cpu_rd_data, 32'h0000_0004);
    cpu_addr = 32'hFFFF_0000;
    #1;
    checkVal("rst_mid_count", cpu_rd_data, 32'd0);
    step(); step();
    rstb = 1'b1;
    tx_ready = 1'b0;
    rd(32'hFFFF_0000);
    checkVal("post_rst_count", sRd, 32'd0);
    rd(32'hFFFF_0008);
    checkVal("post_rst_status", sRd, 32'h0000_0004);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
